rs_issue_arbiter: RTL

Issue arbiter and occupancy controller for one shared execution unit (EU) fed by several reservation stations. Each cycle it picks one ready reservation station by round-robin and drives that station's `eu_ready`. It tracks how long the EU stays occupied by multi-cycle ops and generates the writeback/wakeup pulse (`wb_en`/`wb_prd`) that the reservation stations use to mark operands ready.

---
 rtl/rs_issue_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// rs_issue_arbiter
//
// Purpose: picks one ready reservation station per cycle to issue into a shared
// execution unit (EU), tracks how long the EU stays occupied by multi-cycle ops,
// and produces the writeback/wakeup pulse for the completing op.
//
// Configuration macro:
//   RS_ARB_FIXED_PRIO_EN - when defined, arbitration is fixed priority (lowest
//                          index wins) and the round-robin pointer is removed.
//                          Undefined (default): round-robin arbitration.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]             RS i has a ready entry
//   req_lat      in   [NUM_REQ*LAT_BITS]    slice i: EU occupancy of RS i's op (0 => 1)
//   req_prd      in   [NUM_REQ*PHYS_REG_BITS] slice i: destination tag of RS i's op
//   flush        in   synchronous pipeline flush
//   grant        out  [NUM_REQ]  one-hot or zero, eu_ready per RS
//   grant_valid  out  OR of grant
//   grant_idx    out  index of granted RS, 0 when none
//   eu_busy      out  EU cannot accept a new op this cycle
//   wb_en        out  one-cycle completion/wakeup pulse
//   wb_prd       out  tag of completing op, 0 when wb_en is low
// -----------------------------------------------------------------------------
module rs_issue_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int LAT_BITS      = 3,
    parameter int PHYS_REG_BITS = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*LAT_BITS-1:0]       req_lat,
    input  logic [NUM_REQ*PHYS_REG_BITS-1:0]  req_prd,
    input  logic                              flush,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]        grant_idx,
    output logic                              eu_busy,
    output logic                              wb_en,
    output logic [PHYS_REG_BITS-1:0]          wb_prd
);

    localparam int                  IDX_BITS = $clog2(NUM_REQ);
    localparam logic [IDX_BITS:0]   NREQ_W   = (IDX_BITS+1)'(NUM_REQ);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_REQ - 1);

    // cycles until the in-flight op writes back; 0 means nothing in flight
    logic [LAT_BITS-1:0]      r_cnt;
    logic [PHYS_REG_BITS-1:0] r_prd_q;

    logic [LAT_BITS-1:0]      w_lat_arr  [NUM_REQ];
    logic [PHYS_REG_BITS-1:0] w_prd_arr  [NUM_REQ];
    logic [IDX_BITS-1:0]      w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]       w_cand_valid;
    logic [IDX_BITS-1:0]      w_start;
    logic [IDX_BITS-1:0]      w_sel;
    logic [LAT_BITS-1:0]      w_lat_eff;
    logic                     w_eu_free;
    logic                     w_grant_en;

`ifdef RS_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [IDX_BITS-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`endif

    // Candidate k is the request k positions above the search start, wrapped.
    // Building the rotated order here keeps the priority pick below a plain
    // "first set bit" scan.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IDX_BITS:0] w_sum;
            assign w_lat_arr[gi]    = req_lat[gi*LAT_BITS +: LAT_BITS];
            assign w_prd_arr[gi]    = req_prd[gi*PHYS_REG_BITS +: PHYS_REG_BITS];
            assign w_sum            = {1'b0, w_start} + (IDX_BITS+1)'(gi);
            assign w_cand_idx[gi]   = (w_sum >= NREQ_W) ? IDX_BITS'(w_sum - NREQ_W)
                                                        : w_sum[IDX_BITS-1:0];
            assign w_cand_valid[gi] = req_valid[w_cand_idx[gi]];
            assign grant[gi]        = w_grant_en && (w_sel == IDX_BITS'(gi));
        end
    endgenerate

    // Scan from the last candidate down so the earliest valid one wins.
    always_comb begin
        w_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_valid[k]) begin
                w_sel = w_cand_idx[k];
            end
        end
    end

    // The EU is free on the writeback cycle too, giving back-to-back issue.
    assign w_eu_free  = (r_cnt <= LAT_BITS'(1));
    // rst_n gates the grant so nothing issues while reset is held, even though
    // the counter already reads as idle.
    assign w_grant_en = rst_n & w_eu_free & ~flush & (|req_valid);
    assign w_lat_eff  = (w_lat_arr[w_sel] == '0) ? LAT_BITS'(1) : w_lat_arr[w_sel];

    assign grant_valid = w_grant_en;
    assign grant_idx   = w_grant_en ? w_sel : '0;
    assign eu_busy     = (r_cnt > LAT_BITS'(1));
    assign wb_en       = (r_cnt == LAT_BITS'(1)) & ~flush;
    assign wb_prd      = wb_en ? r_prd_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_prd_q <= '0;
        end else if (flush) begin
            // dropping the count kills the in-flight op's writeback
            r_cnt <= '0;
        end else if (w_grant_en) begin
            r_cnt   <= w_lat_eff;
            r_prd_q <= w_prd_arr[w_sel];
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_BITS'(1);
        end
    end

`ifndef RS_ARB_FIXED_PRIO_EN
    // pointer moves past the winner; held across flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_en) begin
            r_rr_ptr <= (w_sel == LAST_IDX) ? '0 : w_sel + IDX_BITS'(1);
        end
    end
`endif

endmodule
